// File: rtl/cy_mux_pkg.sv
// Shared constants and helpers for the cy_mux_scan registered N-to-1 multiplexer.
package cy_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAN  = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    // Minimum bits to hold indices 0..n-1; at least 1 so a 1-bit select always exists.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cy_mux_nx1.sv
// Combinational N-to-1 selector; an out-of-range select yields all zeros.
module cy_mux_nx1 import cy_mux_pkg::*; #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    localparam int SEL_W   = clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] i_a,
    input  logic [SEL_W-1:0]          i_s,
    output logic [WIDTH-1:0]          o_y
);

    always_comb begin
        o_y = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (i_s == SEL_W'(k)) o_y = i_a[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/cy_mux_scan.sv
// Registered N-channel mux with manual select and round-robin auto-scan.
// state   | meaning
// IDLE    | out of reset, no sample taken yet
// MAN     | output follows i_sel_in
// SCAN    | round-robin over channels, i_dwell cycles each
module cy_mux_scan import cy_mux_pkg::*; #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int DWELL_W  = 8,
    localparam int SEL_W   = clog2(CHANNELS)
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_en,
    input  logic                      i_mode,
    input  logic [SEL_W-1:0]          i_sel_in,
    input  logic [DWELL_W-1:0]        i_dwell,
    input  logic [CHANNELS*WIDTH-1:0] i_a,
    output logic [WIDTH-1:0]          o_y,
    output logic [SEL_W-1:0]          o_sel_out,
    output logic                      o_y_valid,
    output logic                      o_wrap,
    output logic                      o_sel_err
);

    localparam logic [SEL_W:0]   CH_LIM   = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);

    logic [1:0]         r_state;
    logic [SEL_W-1:0]   r_chan;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell_lat;
    logic [WIDTH-1:0]   r_y;
    logic [SEL_W-1:0]   r_sel_out;
    logic               r_y_valid;
    logic               r_wrap;
    logic               r_sel_err;

    logic               w_scan;
    logic               w_restart;
    logic [SEL_W-1:0]   w_chan;
    logic [DWELL_W-1:0] w_cnt;
    logic [DWELL_W-1:0] w_dwell_eff;
    logic [DWELL_W-1:0] w_dwell_use;
    logic               w_last;
    logic               w_chan_end;
    logic               w_sel_oor;
    logic [SEL_W-1:0]   w_mux_s;
    logic [WIDTH-1:0]   w_mux_y;

    // Entering scan from any other state restarts at channel 0 on the same edge.
    assign w_scan      = (i_mode == MODE_SCAN);
    assign w_restart   = (r_state != ST_SCAN);
    assign w_chan      = w_restart ? '0 : r_chan;
    assign w_cnt       = w_restart ? '0 : r_cnt;
    assign w_dwell_eff = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
    assign w_dwell_use = (w_cnt == '0) ? w_dwell_eff : r_dwell_lat;
    assign w_last      = (w_cnt == w_dwell_use - DWELL_W'(1));
    assign w_chan_end  = (w_chan == CH_LAST);
    assign w_sel_oor   = ({1'b0, i_sel_in} >= CH_LIM);
    assign w_mux_s     = w_scan ? w_chan : i_sel_in;

    cy_mux_nx1 #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_mux (
        .i_a (i_a),
        .i_s (w_mux_s),
        .o_y (w_mux_y)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_chan      <= '0;
            r_cnt       <= '0;
            r_dwell_lat <= DWELL_W'(1);
            r_y         <= '0;
            r_sel_out   <= '0;
            r_y_valid   <= 1'b0;
            r_wrap      <= 1'b0;
            r_sel_err   <= 1'b0;
        end else if (!i_en) begin
            r_y_valid <= 1'b0;
            r_wrap    <= 1'b0;
        end else if (!w_scan) begin
            r_state <= ST_MAN;
            r_wrap  <= 1'b0;
            if (w_sel_oor) begin
                r_y       <= '0;
                r_y_valid <= 1'b0;
                r_sel_err <= 1'b1;
            end else begin
                r_y       <= w_mux_y;
                r_sel_out <= i_sel_in;
                r_y_valid <= 1'b1;
                r_sel_err <= 1'b0;
            end
        end else begin
            r_state   <= ST_SCAN;
            r_y       <= w_mux_y;
            r_sel_out <= w_chan;
            r_sel_err <= 1'b0;
            r_y_valid <= w_last;
            r_wrap    <= w_last && w_chan_end;
            if (w_cnt == '0) r_dwell_lat <= w_dwell_eff;
            if (w_last) begin
                r_cnt  <= '0;
                r_chan <= w_chan_end ? '0 : w_chan + SEL_W'(1);
            end else begin
                r_cnt  <= w_cnt + DWELL_W'(1);
                r_chan <= w_chan;
            end
        end
    end

    assign o_y       = r_y;
    assign o_sel_out = r_sel_out;
    assign o_y_valid = r_y_valid;
    assign o_wrap    = r_wrap;
    assign o_sel_err = r_sel_err;

endmodule

// File: tb/tb_cy_mux_scan.sv
// Directed bench for cy_mux_scan with 5 channels of 4-bit data (non-power-of-2 channel count).
module tb_cy_mux_scan;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 5;
    localparam int DWELL_W  = 8;
    localparam int SEL_W    = 3;

    logic                      clk;
    logic                      reset_n;
    logic                      en;
    logic                      mode;
    logic [SEL_W-1:0]          sel_in;
    logic [DWELL_W-1:0]        dwell;
    logic [CHANNELS*WIDTH-1:0] a;
    logic [WIDTH-1:0]          y;
    logic [SEL_W-1:0]          sel_out;
    logic                      y_valid;
    logic                      wrap;
    logic                      sel_err;

    int n_assert;
    int n_fail;

    cy_mux_scan #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL_W(DWELL_W)) dut (
        .i_clock   (clk),
        .i_reset_n (reset_n),
        .i_en      (en),
        .i_mode    (mode),
        .i_sel_in  (sel_in),
        .i_dwell   (dwell),
        .i_a       (a),
        .o_y       (y),
        .o_sel_out (sel_out),
        .o_y_valid (y_valid),
        .o_wrap    (wrap),
        .o_sel_err (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_y, input int e_sel, input int e_v,
                           input int e_w, input int e_err);
        chk({tag, ".y"},       32'(y),       32'(e_y));
        chk({tag, ".sel_out"}, 32'(sel_out), 32'(e_sel));
        chk({tag, ".y_valid"}, 32'(y_valid), 32'(e_v));
        chk({tag, ".wrap"},    32'(wrap),    32'(e_w));
        chk({tag, ".sel_err"}, 32'(sel_err), 32'(e_err));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        en       = 1'b1;
        mode     = 1'b1;
        sel_in   = '0;
        dwell    = 8'd1;
        for (int k = 0; k < CHANNELS; k++) a[k*WIDTH +: WIDTH] = 4'(k + 3);

        // reset held two cycles with en=1, mode=scan
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0);

        // scan, dwell=1: 0,1,2,3,4,0 all valid, wrap with channel 4
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all($sformatf("scan_d1[%0d]", i), (i % 5) + 3, i % 5, 1, ((i % 5) == 4) ? 1 : 0, 0);
        end

        // manual mode
        mode   = 1'b0;
        sel_in = 3'd4;
        tick();
        chk_all("man_sel4", 7, 4, 1, 0, 0);
        sel_in = 3'd6;
        tick();
        chk_all("man_sel6_oor", 0, 4, 0, 0, 1);
        sel_in = 3'd5;
        tick();
        chk_all("man_sel5_oor", 0, 4, 0, 0, 1);
        sel_in = 3'd2;
        tick();
        chk_all("man_sel2", 5, 2, 1, 0, 0);

        // scan, dwell=3: valid every 3rd cycle, 15-cycle frame
        mode  = 1'b1;
        dwell = 8'd3;
        for (int t = 1; t <= 15; t++) begin
            tick();
            chk_all($sformatf("scan_d3[%0d]", t), ((t - 1) / 3) + 3, (t - 1) / 3,
                    ((t % 3) == 0) ? 1 : 0, (t == 15) ? 1 : 0, 0);
        end

        // dwell=0 acts as dwell=1
        dwell = 8'd0;
        tick();
        chk_all("d0_ch0", 3, 0, 1, 0, 0);
        tick();
        chk_all("d0_ch1", 4, 1, 1, 0, 0);

        // dwell 3 -> 2 mid-channel: channel 2 lasts 3, channel 3 lasts 2
        dwell = 8'd3;
        tick();
        chk_all("dchg_c2_0", 5, 2, 0, 0, 0);
        dwell = 8'd2;
        tick();
        chk_all("dchg_c2_1", 5, 2, 0, 0, 0);
        tick();
        chk_all("dchg_c2_2", 5, 2, 1, 0, 0);
        tick();
        chk_all("dchg_c3_0", 6, 3, 0, 0, 0);
        tick();
        chk_all("dchg_c3_1", 6, 3, 1, 0, 0);

        // en gap of 4 cycles mid-dwell on channel 4
        tick();
        chk_all("gap_pre", 7, 4, 0, 0, 0);
        en = 1'b0;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk_all($sformatf("gap[%0d]", g), 7, 4, 0, 0, 0);
        end
        en = 1'b1;
        tick();
        chk_all("gap_resume_wrap", 7, 4, 1, 1, 0);
        // disabling right after a valid/wrap edge forces both low
        en = 1'b0;
        tick();
        chk_all("gap_force_low", 7, 4, 0, 0, 0);
        en = 1'b1;
        tick();
        chk_all("gap_next_frame", 3, 0, 0, 0, 0);

        // mode switch at channel 3
        dwell = 8'd1;
        tick();
        chk_all("ms_c0", 3, 0, 1, 0, 0);
        tick();
        tick();
        chk_all("ms_c2", 5, 2, 1, 0, 0);
        mode   = 1'b0;
        sel_in = 3'd1;
        tick();
        chk_all("ms_man1", 4, 1, 1, 0, 0);
        mode = 1'b1;
        tick();
        chk_all("ms_rescan", 3, 0, 1, 0, 0);

        // reset mid-scan at channel 3
        tick();
        tick();
        chk_all("rst_pre_c2", 5, 2, 1, 0, 0);
        reset_n = 1'b0;
        tick();
        chk_all("rst_mid", 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        a = {4'h1, 4'h2, 4'h3, 4'h4, 4'hA};
        tick();
        chk_all("rst_after_c0", 32'hA, 0, 1, 0, 0);
        tick();
        chk_all("rst_after_c1", 4, 1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
